regfile_sched: RTL and testbench
================================

// Module: regfile_sched
// PURPOSE
//   Access scheduler for the 8x16 LC-3 register file (2 read ports, 1 write port,
//   reads registered on clk). Shares the write port between two writeback sources
//   (ALU, memory) with round-robin arbitration. Runs operand-read requests through
//   the 1-cycle regfile read latency into a response FIFO.
//   Resolves same-cycle read/write hazards on one register.
//   Sits between decode/execute and the regfile; drives all regfile select/load pins.
// PARAMETERS
//   RSP_DEPTH  2   response FIFO entries (>=1); 2 gives one read per cycle sustained
// PORTS
//   clk           in   1   clock; all state updates on posedge
//   rst_n         in   1   asynchronous active-low reset
//   rd_req_valid  in   1   operand-read request valid
//   rd_req_ready  out  1   request accepted when valid&ready at posedge
//   rd_sr1/rd_sr2 in   3   source register indices
//   rd_rsp_valid  out  1   response FIFO head valid
//   rd_rsp_ready  in   1   consumer pops head when valid&ready
//   rd_sr1_data   out  16  head operand 1
//   rd_sr2_data   out  16  head operand 2
//   wa_valid/wa_ready  in/out  1   ALU writeback handshake
//   wa_dr, wa_data     in  3, 16   ALU destination index and data
//   wb_valid/wb_ready  in/out  1   memory writeback handshake
//   wb_dr, wb_data     in  3, 16   memory destination index and data
//   rf_sr1_sel, rf_sr2_sel  out  3   regfile read selects
//   rf_dr_sel, rf_dr_in     out  3, 16   regfile write index/data
//   rf_load_reg             out  1   regfile write enable
//   rf_sr1_out, rf_sr2_out  in   16  regfile registered read data
// BEHAVIOUR
//   Reset: S1 stage, FIFO and rr pointer cleared (pointer favours wa next).
//     While rst_n=0: all *_ready=0, rd_rsp_valid=0, rf_load_reg=0, sels=0.
//     Reset mid-read discards S1 and all FIFO contents.
//   Write arbitration (combinational grant, one write per cycle):
//     - only wa valid -> wa; only wb valid -> wb
//     - both valid -> side not granted last; pointer updates only on contention
//     - wX_ready = grant_X.
//     - rf_load_reg = any grant; rf_dr_sel/rf_dr_in = granted source, 0 when idle.
//     - Write takes effect at the same posedge.
//   Read path:
//     - rf_sr1/2_sel = rd_sr1/2 (combinational).
//     - Accept when credits allow: S1_valid + count - pop < RSP_DEPTH
//       (pop = rd_rsp_valid & rd_rsp_ready).
//     - On accept, S1 latches hit1/hit2/wdata.
//     - Next cycle S1 pushes {hit1?wdata:rf_sr1_out, hit2?wdata:rf_sr2_out}.
//     - Push into a full FIFO is impossible by construction (assertion).
//     - Accept-to-rd_rsp_valid latency: 2 clk (empty FIFO).
//   Hazard: regfile samples reads before the same-edge write, so it returns the
//     stale value for a read that coincides with a write to the same index.
//     hitN = granted write this cycle & rf_dr_sel == rd_srN. Handling per
//     CONFIGURATION. Writes one or more cycles before a read are seen directly.
//   FIFO: push and pop in the same cycle on a full FIFO is legal; count is
//     unchanged. Pointers wrap mod RSP_DEPTH.
//   Same-index sr1==sr2: both operands are forwarded identically.
// CONFIGURATION
//   REGFILE_SCHED_BYPASS_EN defined: on hitN, wdata is forwarded; no stall.
//   Undefined: hit1|hit2 forces rd_req_ready=0 that cycle and the request retries
//     next cycle; hit flags are tied 0.
// TESTING
//   1 Reset and idle: all ready, valid and load outputs 0.
//     Deassert rst_n -> wa_ready follows wa_valid.
//   2 wa_valid=1, wa_dr=3, data=16'h1234; next cycle read sr1=3, sr2=0
//     -> rsp 2 clk later: sr1_data=16'h1234.
//   3 wa and wb both valid for 4 cycles, dr=1/2
//     -> grants alternate wa,wb,wa,wb; rf_load_reg=1 each cycle.
//   4 Write R5=16'hBEEF in the same cycle as read sr1=5 -> BYPASS_EN: no stall,
//     rsp sr1=16'hBEEF. No macro: ready=0 that cycle, accepted next, rsp=16'hBEEF.
//   5 Back-to-back reads with rd_rsp_ready=1 -> one rsp per cycle.
//     Hold rd_rsp_ready=0 -> ready drops after RSP_DEPTH accepts, no data lost.
//   6 rst_n low with 2 rsps queued -> rd_rsp_valid=0 immediately (async);
//     after release, FIFO is empty.

Source files
------------

// File: rtl/regfile_sched.sv
// regfile_sched: LC-3 regfile write arbiter and read scheduler; REGFILE_SCHED_BYPASS_EN forwards same-cycle writes instead of stalling
module regfile_sched #(
    parameter int RSP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req_valid,
    output logic        rd_req_ready,
    input  logic [2:0]  rd_sr1,
    input  logic [2:0]  rd_sr2,
    output logic        rd_rsp_valid,
    input  logic        rd_rsp_ready,
    output logic [15:0] rd_sr1_data,
    output logic [15:0] rd_sr2_data,
    input  logic        wa_valid,
    output logic        wa_ready,
    input  logic [2:0]  wa_dr,
    input  logic [15:0] wa_data,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [2:0]  wb_dr,
    input  logic [15:0] wb_data,
    output logic [2:0]  rf_sr1_sel,
    output logic [2:0]  rf_sr2_sel,
    output logic [2:0]  rf_dr_sel,
    output logic [15:0] rf_dr_in,
    output logic        rf_load_reg,
    input  logic [15:0] rf_sr1_out,
    input  logic [15:0] rf_sr2_out
);
    localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1) + 1;
    logic prio_b, grant_a, grant_b, hit1, hit2, stall, accept, pop, push;
    logic s1_v, s1_h1, s1_h2;
    logic [15:0] s1_wd;
    logic [31:0] mem [RSP_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] count;
    always_comb begin
        grant_a = rst_n & wa_valid & (~wb_valid | ~prio_b);
        grant_b = rst_n & wb_valid & (~wa_valid | prio_b);
        rf_load_reg = grant_a | grant_b;
        rf_dr_sel = grant_a ? wa_dr : grant_b ? wb_dr : 3'd0;
        rf_dr_in = grant_a ? wa_data : grant_b ? wb_data : 16'd0;
        rf_sr1_sel = rst_n ? rd_sr1 : 3'd0;
        rf_sr2_sel = rst_n ? rd_sr2 : 3'd0;
    end
    assign wa_ready = grant_a;
    assign wb_ready = grant_b;
    // The regfile returns the pre-write value for a read colliding with this edge's write.
`ifdef REGFILE_SCHED_BYPASS_EN
    assign hit1 = rf_load_reg && rf_dr_sel == rd_sr1;
    assign hit2 = rf_load_reg && rf_dr_sel == rd_sr2;
    assign stall = 1'b0;
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
    assign stall = rf_load_reg && (rf_dr_sel == rd_sr1 || rf_dr_sel == rd_sr2);
`endif
    assign rd_rsp_valid = rst_n && count != '0;
    assign pop = rd_rsp_valid & rd_rsp_ready;
    assign push = s1_v;
    assign rd_req_ready = rst_n && !stall && (CW'(s1_v) + count - CW'(pop) < CW'(RSP_DEPTH));
    assign accept = rd_req_valid & rd_req_ready;
    assign rd_sr1_data = mem[rp][31:16];
    assign rd_sr2_data = mem[rp][15:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b <= 1'b0;
            s1_v <= 1'b0;
            s1_h1 <= 1'b0;
            s1_h2 <= 1'b0;
            s1_wd <= '0;
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (wa_valid && wb_valid) prio_b <= grant_a;
            s1_v <= accept;
            if (accept) {s1_h1, s1_h2, s1_wd} <= {hit1, hit2, rf_dr_in};
            if (push) wp <= wp == PW'(RSP_DEPTH - 1) ? '0 : wp + PW'(1);
            if (pop) rp <= rp == PW'(RSP_DEPTH - 1) ? '0 : rp + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {s1_h1 ? s1_wd : rf_sr1_out, s1_h2 ? s1_wd : rf_sr2_out};
        if (rst_n && push && !pop) assert (count < CW'(RSP_DEPTH));
    end
endmodule

// File: tb/tb_regfile_sched.sv
// tb_regfile_sched: directed scoreboard bench for regfile_sched with a behavioural 8x16 regfile
module tb_regfile_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rd_req_valid, rd_req_ready, rd_rsp_valid, rd_rsp_ready;
    logic [2:0] rd_sr1, rd_sr2, wa_dr, wb_dr, rf_sr1_sel, rf_sr2_sel, rf_dr_sel;
    logic [15:0] rd_sr1_data, rd_sr2_data, wa_data, wb_data, rf_dr_in, rf_sr1_out, rf_sr2_out;
    logic wa_valid, wa_ready, wb_valid, wb_ready, rf_load_reg;
    logic [15:0] regs [8];
    logic [15:0] sh [8];
    logic [31:0] sb [$];
    logic [31:0] nxt;
    int total = 0;
    int passed = 0;
    int fails = 0;

    regfile_sched #(.RSP_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_sr1(rd_sr1), .rd_sr2(rd_sr2),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rd_sr1_data(rd_sr1_data), .rd_sr2_data(rd_sr2_data),
        .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_dr(wa_dr), .wa_data(wa_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dr(wb_dr), .wb_data(wb_data),
        .rf_sr1_sel(rf_sr1_sel), .rf_sr2_sel(rf_sr2_sel),
        .rf_dr_sel(rf_dr_sel), .rf_dr_in(rf_dr_in), .rf_load_reg(rf_load_reg),
        .rf_sr1_out(rf_sr1_out), .rf_sr2_out(rf_sr2_out)
    );

    always #5 clk = ~clk;

    // Regfile model: reads sample the pre-write contents at the same edge as the write.
    always @(posedge clk) begin
        rf_sr1_out <= regs[rf_sr1_sel];
        rf_sr2_out <= regs[rf_sr2_sel];
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0;
        end else if (rf_load_reg) begin
            regs[rf_dr_sel] <= rf_dr_in;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic adv;
        #2;
        if (rd_req_valid && rd_req_ready) sb.push_back(nxt);
        if (rd_rsp_valid && rd_rsp_ready) begin
            if (sb.size() == 0) chk("rsp_unexpected", 32'(sb.size()), 32'd1);
            else chk("rsp_data", {rd_sr1_data, rd_sr2_data}, sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rd_req_valid = 1'b0;
        wa_valid = 1'b0;
        wb_valid = 1'b0;
    endtask

    task automatic req(input int a, input int b);
        rd_req_valid = 1'b1;
        rd_sr1 = 3'(a);
        rd_sr2 = 3'(b);
        nxt = {sh[a], sh[b]};
    endtask

    task automatic hazard_read(input string tag);
        #1;
`ifdef REGFILE_SCHED_BYPASS_EN
        chk({tag, "_ready"}, 32'(rd_req_ready), 32'd1);
        adv;
`else
        chk({tag, "_stall"}, 32'(rd_req_ready), 32'd0);
        adv;
        wa_valid = 1'b0;
        wb_valid = 1'b0;
        #1;
        chk({tag, "_retry"}, 32'(rd_req_ready), 32'd1);
        adv;
`endif
        idle;
    endtask

    task automatic drain(input string tag);
        idle;
        rd_rsp_ready = 1'b1;
        repeat (4) adv;
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        idle;
        rd_rsp_ready = 1'b0;
        rd_sr1 = 3'd0;
        rd_sr2 = 3'd0;
        wa_dr = 3'd0;
        wb_dr = 3'd0;
        wa_data = 16'h0;
        wb_data = 16'h0;
        nxt = '0;
        for (int i = 0; i < 8; i++) sh[i] = 16'h0;
        #1 rst_n = 1'b0;
        rd_req_valid = 1'b1;
        rd_sr1 = 3'd5;
        rd_sr2 = 3'd6;
        wa_valid = 1'b1;
        wb_valid = 1'b1;
        wa_dr = 3'd1;
        wb_dr = 3'd2;
        wa_data = 16'hAAAA;
        wb_data = 16'h5555;
        #1;
        chk("rst_ready", 32'({wa_ready, wb_ready, rd_req_ready}), 32'd0);
        chk("rst_valid_load", 32'({rd_rsp_valid, rf_load_reg}), 32'd0);
        chk("rst_sels", 32'({rf_sr1_sel, rf_sr2_sel, rf_dr_sel}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle;
        wa_valid = 1'b1;
        wa_dr = 3'd3;
        wa_data = 16'h1234;
        sh[3] = 16'h1234;
        #1;
        chk("wa_follows", 32'({wa_ready, wb_ready, rf_load_reg}), 32'd5);
        chk("wr_bus", 32'({rf_dr_sel, rf_dr_in}), 32'h31234);
        adv;
        wa_valid = 1'b0;
        req(3, 0);
        #1;
        chk("rd_ready", 32'(rd_req_ready), 32'd1);
        chk("rd_sel", 32'({rf_sr1_sel, rf_sr2_sel}), 32'd24);
        adv;
        idle;
        rd_rsp_ready = 1'b1;
        #1;
        chk("lat_1clk", 32'(rd_rsp_valid), 32'd0);
        adv;
        #1;
        chk("lat_2clk", 32'(rd_rsp_valid), 32'd1);
        adv;
        wa_valid = 1'b1;
        wb_valid = 1'b1;
        wa_dr = 3'd1;
        wa_data = 16'h1111;
        wb_dr = 3'd2;
        wb_data = 16'h2222;
        sh[1] = 16'h1111;
        sh[2] = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_grant", 32'({wa_ready, wb_ready}), (i % 2 == 0) ? 32'd2 : 32'd1);
            chk("rr_load", 32'(rf_load_reg), 32'd1);
            adv;
        end
        idle;
        wa_valid = 1'b1;
        wa_dr = 3'd5;
        wa_data = 16'hBEEF;
        sh[5] = 16'hBEEF;
        req(5, 1);
        hazard_read("hz_wa");
        wb_valid = 1'b1;
        wb_dr = 3'd6;
        wb_data = 16'hCAFE;
        sh[6] = 16'hCAFE;
        req(6, 6);
        hazard_read("hz_same");
        drain("drain_hz");
        for (int i = 0; i < 8; i++) begin
            req(i, 7 - i);
            #1;
            chk("b2b_ready", 32'(rd_req_ready), 32'd1);
            if (i >= 2) chk("b2b_rsp_valid", 32'(rd_rsp_valid), 32'd1);
            adv;
        end
        drain("drain_b2b");
        rd_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(i + 1, i);
            #1;
            chk("bp_ready", 32'(rd_req_ready), (i < 2) ? 32'd1 : 32'd0);
            adv;
        end
        idle;
        #1;
        chk("bp_held", 32'(rd_rsp_valid), 32'd1);
        drain("drain_bp");
        rd_rsp_ready = 1'b0;
        req(3, 5);
        adv;
        req(5, 3);
        adv;
        idle;
        adv;
        adv;
        #1;
        chk("queued", 32'({rd_rsp_valid, rd_req_ready}), 32'd2);
        rst_n = 1'b0;
        wa_valid = 1'b1;
        #1;
        chk("async_rsp_valid", 32'(rd_rsp_valid), 32'd0);
        chk("async_ready_load", 32'({wa_ready, rf_load_reg}), 32'd0);
        sb.delete();
        for (int i = 0; i < 8; i++) sh[i] = 16'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle;
        rd_rsp_ready = 1'b1;
        #1;
        chk("post_rst_empty", 32'(rd_rsp_valid), 32'd0);
        adv;
        adv;
        #1;
        chk("post_rst_empty2", 32'(rd_rsp_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
